// File: rtl/uart_rx_words_if.sv
// Downstream word handshake between the UART word receiver and its consumer.
//   data_o      : packed received word, byte 0 = first byte seen on the line
//   down_valid  : data_o holds a word not yet accepted
//   down_ready  : consumer accepts; a transfer happens when down_valid && down_ready
// master = the receiver (drives data_o/down_valid), slave = the consumer.
interface uart_rx_words_if #(
    parameter int DEPTH = 8
) ();
    logic [DEPTH-1:0][7:0] data_o;
    logic                  down_valid;
    logic                  down_ready;

    modport master (
        output data_o,
        output down_valid,
        input  down_ready
    );

    modport slave (
        input  data_o,
        input  down_valid,
        output down_ready
    );
endinterface

// File: rtl/uart_rx_words.sv
// UART 8N1 receiver and word packer.
// Deserialises LSB-first bytes from rx, collects DEPTH bytes into one packed
// word and offers it downstream on a valid/ready handshake. Framing errors
// and dropped words are reported as single-cycle pulses.
// Ports:
//   clk        : system clock, rising edge
//   arstn      : asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   bus        : word handshake (data_o, down_valid out; down_ready in)
//   frame_err  : 1-cycle pulse, stop bit sampled low (byte discarded)
//   overrun    : 1-cycle pulse, completed word dropped because output still full
module uart_rx_words #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int boadrate = 115200,
    parameter int DEPTH    = 8
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            rx,
    uart_rx_words_if.master bus,
    output logic            frame_err,
    output logic            overrun
);

    localparam int BIT_CYCLES  = CLK_FREQ / boadrate;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam int IDX_W       = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(1'b0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    // Line synchroniser; reset low so a line held low out of reset never
    // looks like a falling edge.
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [2:0]            bit_cnt_r;
    logic [2:0]            bit_cnt_s;
    logic [7:0]            shift_r;
    logic [7:0]            shift_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_s;
    logic                  store_s;
    logic                  done_s;
    logic                  done_r;
    logic                  ferr_s;
    logic [DEPTH-1:0][7:0] word_r;
    logic [DEPTH-1:0][7:0] data_r;
    logic                  valid_r;
    logic                  frame_err_r;
    logic                  overrun_r;

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
            rx_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM state register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, bit timing and byte/word bookkeeping.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        idx_s     = idx_r;
        store_s   = 1'b0;
        done_s    = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (rx_prev_r && !rx_sync_r) begin
                    bit_cnt_s = 3'd0;
                    state_s   = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Half a bit in: confirm the start bit is still low.
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_sync_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_sync_r) begin
                        store_s = 1'b1;
                        state_s = ST_IDLE;
                        if (idx_r == IDX_LAST) begin
                            idx_s  = IDX_ZERO;
                            done_s = 1'b1;
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // A low stop bit may be a break; wait for the line to recover.
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Receive datapath registers: counters, shift register, word assembly.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_r       <= CNT_ZERO;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            idx_r       <= IDX_ZERO;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            word_r      <= '{default: 8'h00};
        end else begin
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            idx_r       <= idx_s;
            done_r      <= done_s;
            frame_err_r <= ferr_s;
            for (int i = 0; i < DEPTH; i++) begin
                if (store_s && (idx_r == IDX_W'(i))) begin
                    word_r[i] <= shift_r;
                end
            end
        end
    end

    // Output word register and handshake. A completed word (done_r) loads
    // when the output is empty or being accepted this cycle; otherwise it is
    // dropped and overrun pulses.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            data_r    <= '{default: 8'h00};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (done_r) begin
                if (!valid_r || bus.down_ready) begin
                    data_r    <= word_r;
                    valid_r   <= 1'b1;
                    overrun_r <= 1'b0;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else begin
                overrun_r <= 1'b0;
                if (valid_r && bus.down_ready) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end
        end
    end

    assign bus.data_o     = data_r;
    assign bus.down_valid = valid_r;
    assign frame_err      = frame_err_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_uart_rx_words.sv
// Self-checking bench for uart_rx_words. Stimulus pushes expected words into
// a queue; a negedge monitor pops and compares on every handshake and counts
// frame_err/overrun pulses. Baud and clock are chosen so one bit is 16 clocks.
module tb_uart_rx_words;

    localparam int CLK_FREQ = 1_843_200;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 8;
    localparam int BC       = CLK_FREQ / BAUD;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic rx    = 1'b1;
    logic frame_err;
    logic overrun;

    uart_rx_words_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_words #(
        .CLK_FREQ(CLK_FREQ),
        .boadrate(BAUD),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .arstn    (arstn),
        .rx       (rx),
        .bus      (bus),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pulse counters and word comparison on handshake.
    always @(negedge clk) begin
        if (arstn) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (bus.down_valid && bus.down_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", bus.data_o);
                end else begin
                    check("word", bus.data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        tick(BC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BC);
        end
        rx = stop_ok;
        tick(BC);
        if (!stop_ok) begin
            rx = 1'b1;
            tick(BC);
        end
    endtask

    // Sends the word byte 0 first; optionally records it as expected.
    task automatic send_word(input logic [63:0] w, input bit expect_it);
        if (expect_it) exp_q.push_back(w);
        for (int i = 0; i < 8; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    logic [7:0] t1_bytes [8];

    initial begin
        t1_bytes = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h40, 8'h30, 8'h20, 8'h10};
        bus.down_ready = 1'b1;
        arstn = 1'b0;
        rx    = 1'b1;
        tick(5);
        check("rst_data", bus.data_o, 64'd0);
        check("rst_valid", {63'd0, bus.down_valid}, 64'd0);
        check("rst_ferr", {63'd0, frame_err}, 64'd0);
        check("rst_ovr", {63'd0, overrun}, 64'd0);
        arstn = 1'b1;
        tick(10);

        // Basic word, bytes sent individually.
        exp_q.push_back(64'h1020_3040_0102_0304);
        for (int i = 0; i < 8; i++) send_byte(t1_bytes[i], 1'b1);
        tick(20);
        check("t1_drained", 64'(exp_q.size()), 64'd0);
        check("t1_valid_dropped", {63'd0, bus.down_valid}, 64'd0);

        // Two back-to-back words with no idle gap.
        send_word(64'h8877_6655_4433_2211, 1'b1);
        send_word(64'h00FF_A55A_0FF0_C33C, 1'b1);
        tick(20);
        check("t2_drained", 64'(exp_q.size()), 64'd0);
        check("t2_ferr", 64'(ferr_cnt), 64'd0);
        check("t2_ovr", 64'(ovr_cnt), 64'd0);

        // Bad stop bit: byte discarded, following word intact.
        send_byte(8'hA5, 1'b0);
        tick(5);
        check("t3_ferr_once", 64'(ferr_cnt), 64'd1);
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        tick(20);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Quarter-bit glitch must not start a byte.
        rx = 1'b0;
        tick(BC / 4);
        rx = 1'b1;
        tick(2 * BC);
        send_word(64'h0123_4567_89AB_CDEF, 1'b1);
        tick(20);
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        check("t4_ferr", 64'(ferr_cnt), 64'd1);

        // Back-pressure: second word dropped, first held.
        bus.down_ready = 1'b0;
        send_word(64'h1111_2222_3333_4444, 1'b1);
        send_word(64'h5555_6666_7777_8888, 1'b0);
        tick(20);
        check("t5_ovr_once", 64'(ovr_cnt), 64'd1);
        check("t5_valid_held", {63'd0, bus.down_valid}, 64'd1);
        check("t5_data_held", bus.data_o, 64'h1111_2222_3333_4444);
        check("t5_pending", 64'(exp_q.size()), 64'd1);
        bus.down_ready = 1'b1;
        tick(5);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        check("t5_valid_dropped", {63'd0, bus.down_valid}, 64'd0);

        // Reset after a partial word.
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h55, 1'b1);
        tick(BC);
        arstn = 1'b0;
        tick(3);
        check("t6_rst_data", bus.data_o, 64'd0);
        check("t6_rst_valid", {63'd0, bus.down_valid}, 64'd0);
        arstn = 1'b1;
        tick(10);
        send_word(64'hFEDC_BA98_7654_3210, 1'b1);
        tick(20);
        check("t6_drained", 64'(exp_q.size()), 64'd0);
        check("t6_ferr", 64'(ferr_cnt), 64'd1);
        check("t6_ovr", 64'(ovr_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
